// File: rtl/alu_pkg.sv
// Shared ALU lane definitions: lane geometry, writeback FSM states and lane-count helper.
package alu_pkg;

  localparam int unsigned LANES      = 6;
  localparam int unsigned LANE_W     = 32;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned LANE_IDX_W = $clog2(LANES);

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } wb_state_t;

  // Index of the final lane written for a result: lane 0 for scalar, top lane for vector.
  function automatic lane_idx_t last_lane(input logic op);
    return op ? lane_idx_t'(LANES - 1) : lane_idx_t'(0);
  endfunction

endpackage

// File: rtl/alu_lane_writeback_if.sv
// ALU result handshake: producer drives the result, consumer returns in_ready.
interface alu_lane_writeback_if;
  import alu_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*LANE_W-1:0] in_data;
  logic                    in_op;
  logic                    in_flagz;
  logic [ADDR_W-1:0]       in_base;

  modport master (
    output in_valid, in_data, in_op, in_flagz, in_base,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_data, in_op, in_flagz, in_base,
    output in_ready
  );

endinterface

// File: rtl/alu_lane_select.sv
// Combinational LANES:1 lane mux; out-of-range indices return zero.
module alu_lane_select
  import alu_pkg::*;
(
  input  logic [LANES*LANE_W-1:0] data_i,
  input  lane_idx_t               lane_i,
  output logic [LANE_W-1:0]       word_o
);

  always_comb begin
    word_o = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      if (lane_i == lane_idx_t'(k)) begin
        word_o = data_i[k*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: rtl/alu_lane_writeback.sv
// Captures one ALU result per handshake and writes its lanes to data memory, one per beat.
module alu_lane_writeback
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  alu_lane_writeback_if.slave in_if,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LANE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              done,
  output logic              done_flagz,
  output logic              busy
);

  wb_state_t               state_q;
  lane_idx_t               lane_q;
  logic [LANES*LANE_W-1:0] data_q;
  logic                    op_q;
  logic                    flagz_q;
  logic [ADDR_W-1:0]       base_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      data_q  <= '0;
      op_q    <= 1'b0;
      flagz_q <= 1'b0;
      base_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_if.in_valid) begin
            data_q  <= in_if.in_data;
            op_q    <= in_if.in_op;
            flagz_q <= in_if.in_flagz;
            base_q  <= in_if.in_base;
            lane_q  <= '0;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          // Stalled beats keep lane_q, so address and data stay stable.
          if (mem_ready) begin
            if (lane_q == last_lane(op_q)) begin
              state_q <= DONE;
            end else begin
              lane_q <= lane_q + lane_idx_t'(1);
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  alu_lane_select u_lane_select (
    .data_i (data_q),
    .lane_i (lane_q),
    .word_o (mem_wdata)
  );

  // Outputs decode only from registered state, never from in_* directly.
  assign in_if.in_ready = (state_q == IDLE);
  assign mem_we         = (state_q == WRITE);
  assign mem_addr       = base_q + ADDR_W'(lane_q);
  assign done           = (state_q == DONE);
  assign done_flagz     = done & flagz_q;
  assign busy           = (state_q != IDLE);

endmodule
